// File: rtl/pair_stim_pkg.sv
// Shared types and constants for the pair stimulus generator.
// Holds the FSM state enum, the Galois LFSR tap mask, the LFSR reset value,
// the default seed and the single-step LFSR helper.
package pair_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] PAIR_STIM_LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] PAIR_STIM_LFSR_RST  = 32'h0000_0001;
  localparam logic [31:0] PAIR_STIM_SEED_DFLT = 32'h0000_0001;

  // One step of the 32-bit right-shift Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? PAIR_STIM_LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/pair_stim_lfsr.sv
// 32-bit Galois LFSR with load and advance enables, plus replication of the
// next state onto a WIDTH-bit data vector (bit i = lfsr[i % 32]).
// Ports:
//   clk, rst_n      : clock, async active-low reset (state resets to 32'h1)
//   load, load_val  : load load_val on the next edge (has priority)
//   adv             : advance one step on the next edge
//   data_nxt_c      : replicated value the register takes on the next edge
module pair_stim_lfsr
  import pair_stim_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [31:0]      load_val,
  input  logic             adv,
  output logic [WIDTH-1:0] data_nxt_c
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_nxt;

  // Next-state select: load beats advance, otherwise hold.
  always_comb begin
    lfsr_nxt = lfsr_q;
    if (load) begin
      lfsr_nxt = load_val;
    end else if (adv) begin
      lfsr_nxt = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PAIR_STIM_LFSR_RST;
    end else begin
      lfsr_q <= lfsr_nxt;
    end
  end

  // Widths above 32 wrap around and repeat the low LFSR bits.
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_rep
    assign data_nxt_c[g] = lfsr_nxt[g % 32];
  end

endmodule

// File: rtl/pair_stim_gen.sv
// Pair stimulus generator: after a start pulse, streams a programmed number
// of identical pseudo-random vector pairs on sig0/sig1 under valid/ready,
// then pulses done for one cycle.
// Optional feature macro: PAIR_STIM_INJECT_EN adds pair_stim_inject_ip and
// inverts sig1[0] on the vector whose index equals the latched inject value.
// Ports:
//   pair_stim_clk_ip, pair_stim_rst_n_ip : clock, async active-low reset
//   pair_stim_start_ip/count_ip/seed_ip  : run request and its parameters
//   pair_stim_ready_ip                   : consumer accepts current vector
//   pair_stim_valid_op, sig0_op, sig1_op : vector pair output
//   pair_stim_busy_op, done_op, sent_op  : run status
//   pair_stim_inject_ip                  : corrupted vector index (optional)
module pair_stim_gen
  import pair_stim_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] SEED_DFLT = PAIR_STIM_SEED_DFLT
) (
  input  logic             pair_stim_clk_ip,
  input  logic             pair_stim_rst_n_ip,
  input  logic             pair_stim_start_ip,
  input  logic [CNT_W-1:0] pair_stim_count_ip,
  input  logic [31:0]      pair_stim_seed_ip,
  input  logic             pair_stim_ready_ip,
  output logic             pair_stim_valid_op,
  output logic [WIDTH-1:0] pair_stim_sig0_op,
  output logic [WIDTH-1:0] pair_stim_sig1_op,
  output logic             pair_stim_busy_op,
  output logic             pair_stim_done_op,
  output logic [CNT_W-1:0] pair_stim_sent_op
`ifdef PAIR_STIM_INJECT_EN
  ,
  input  logic [CNT_W-1:0] pair_stim_inject_ip
`endif
);

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] sent_q, sent_nxt;
  logic             valid_q, busy_q, done_q;
  logic [WIDTH-1:0] sig0_q, sig1_q;
  logic             load_c, adv_c, hs_c;
  logic [31:0]      seed_eff_c;
  logic [WIDTH-1:0] data_nxt_c;
  logic             flip_c;
`ifdef PAIR_STIM_INJECT_EN
  logic [CNT_W-1:0] inj_q, inj_nxt;
`endif

  assign hs_c       = valid_q && pair_stim_ready_ip;
  assign seed_eff_c = (pair_stim_seed_ip == 32'h0) ? SEED_DFLT : pair_stim_seed_ip;

  pair_stim_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk        (pair_stim_clk_ip),
    .rst_n      (pair_stim_rst_n_ip),
    .load       (load_c),
    .load_val   (seed_eff_c),
    .adv        (adv_c),
    .data_nxt_c (data_nxt_c)
  );

  // Next-state, counters and LFSR control.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    sent_nxt  = sent_q;
    load_c    = 1'b0;
    adv_c     = 1'b0;
`ifdef PAIR_STIM_INJECT_EN
    inj_nxt   = inj_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pair_stim_start_ip) begin
          load_c   = 1'b1;
          sent_nxt = '0;
          cnt_nxt  = pair_stim_count_ip;
`ifdef PAIR_STIM_INJECT_EN
          inj_nxt  = pair_stim_inject_ip;
`endif
          state_nxt = (pair_stim_count_ip != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (hs_c) begin
          adv_c    = 1'b1;
          sent_nxt = sent_q + CNT_W'(1);
          if (sent_nxt == cnt_q) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The vector about to be shown has index sent_nxt; flag it for corruption.
`ifdef PAIR_STIM_INJECT_EN
  assign flip_c = (sent_nxt == inj_nxt);
`else
  assign flip_c = 1'b0;
`endif

  always_ff @(posedge pair_stim_clk_ip or negedge pair_stim_rst_n_ip) begin
    if (!pair_stim_rst_n_ip) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sent_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig0_q  <= '0;
      sig1_q  <= '0;
`ifdef PAIR_STIM_INJECT_EN
      inj_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      sent_q  <= sent_nxt;
      valid_q <= (state_nxt == ST_RUN);
      busy_q  <= (state_nxt == ST_RUN);
      done_q  <= (state_nxt == ST_DONE);
      sig0_q  <= (state_nxt == ST_RUN) ? data_nxt_c : '0;
      sig1_q  <= (state_nxt == ST_RUN) ? (data_nxt_c ^ WIDTH'(flip_c)) : '0;
`ifdef PAIR_STIM_INJECT_EN
      inj_q   <= inj_nxt;
`endif
    end
  end

  assign pair_stim_valid_op = valid_q;
  assign pair_stim_busy_op  = busy_q;
  assign pair_stim_done_op  = done_q;
  assign pair_stim_sig0_op  = sig0_q;
  assign pair_stim_sig1_op  = sig1_q;
  assign pair_stim_sent_op  = sent_q;

endmodule

// File: tb/tb_pair_stim_gen.sv
// Self-checking bench for pair_stim_gen (WIDTH=40 to exercise replication).
// Expected vectors come from a queue built by iterating the LFSR formula.
module tb_pair_stim_gen;

  localparam int unsigned WIDTH = 40;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [31:0]      seed;
  logic             ready;
  logic             valid, busy, done;
  logic [WIDTH-1:0] sig0, sig1;
  logic [CNT_W-1:0] sent;
`ifdef PAIR_STIM_INJECT_EN
  logic [CNT_W-1:0] inject;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] got_q[$];

  always #5 clk = ~clk;

  pair_stim_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .pair_stim_clk_ip    (clk),
    .pair_stim_rst_n_ip  (rst_n),
    .pair_stim_start_ip  (start),
    .pair_stim_count_ip  (count),
    .pair_stim_seed_ip   (seed),
    .pair_stim_ready_ip  (ready),
    .pair_stim_valid_op  (valid),
    .pair_stim_sig0_op   (sig0),
    .pair_stim_sig1_op   (sig1),
    .pair_stim_busy_op   (busy),
    .pair_stim_done_op   (done),
    .pair_stim_sent_op   (sent)
`ifdef PAIR_STIM_INJECT_EN
    ,
    .pair_stim_inject_ip (inject)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // 40-bit vector: bits 32..39 repeat LFSR bits 0..7.
  function automatic logic [WIDTH-1:0] ref_expand(input logic [31:0] s);
    return {s[7:0], s};
  endfunction

  // mode 0: ready always high; 1: random ready plus ignored start noise;
  // 2: ready low for 3 cycles after the first handshake.
  task automatic run(input int cnt, input logic [31:0] sd, input int inj, input int mode);
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] e1;
    logic [31:0]      s;
    int               hs;
    int               stall;
    int               budget;
    logic             r;
    hs    = 0;
    stall = 0;
    s     = (sd == 32'h0) ? 32'h1 : sd;
    for (int k = 0; k < cnt; k++) begin
      exp_q.push_back(ref_expand(s));
      s = ref_step(s);
    end
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    count = CNT_W'(cnt);
    seed  = sd;
    ready = 1'b0;
`ifdef PAIR_STIM_INJECT_EN
    inject = CNT_W'(inj);
`endif
    @(negedge clk);
    start  = 1'b0;
    budget = 30 * cnt + 10;
    while (exp_q.size() != 0 && budget > 0) begin
      budget--;
      check_val("valid_run", 64'(valid), 64'd1);
      check_val("busy_run",  64'(busy),  64'd1);
      check_val("done_run",  64'(done),  64'd0);
      check_val("sent_run",  64'(sent),  64'(hs));
      check_val("sig0",      64'(sig0),  64'(exp_q[0]));
      e1 = exp_q[0];
`ifdef PAIR_STIM_INJECT_EN
      if (hs == inj) e1[0] = ~e1[0];
`endif
      check_val("sig1",      64'(sig1),  64'(e1));
      case (mode)
        1:       r = 1'($urandom_range(0, 1));
        2: begin
          r = !(hs == 1 && stall < 3);
          if (!r) stall++;
        end
        default: r = 1'b1;
      endcase
      if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        count = CNT_W'($urandom_range(0, 7));
        seed  = $urandom;
      end
      ready = r;
      if (r) begin
        got_q.push_back(sig0);
        void'(exp_q.pop_front());
        hs++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b0;
    if (exp_q.size() != 0) check_val("timeout", 64'(exp_q.size()), 64'd0);
    check_val("valid_done", 64'(valid), 64'd0);
    check_val("busy_done",  64'(busy),  64'd0);
    check_val("done_pulse", 64'(done),  64'd1);
    check_val("sent_done",  64'(sent),  64'(cnt));
    @(negedge clk);
    check_val("done_clear", 64'(done),  64'd0);
    check_val("valid_idle", 64'(valid), 64'd0);
    check_val("busy_idle",  64'(busy),  64'd0);
    check_val("sent_idle",  64'(sent),  64'(cnt));
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    count = '0;
    seed  = '0;
    ready = 1'b0;
`ifdef PAIR_STIM_INJECT_EN
    inject = '0;
`endif
    #12;
    check_val("rst_valid", 64'(valid), 64'd0);
    check_val("rst_busy",  64'(busy),  64'd0);
    check_val("rst_done",  64'(done),  64'd0);
    check_val("rst_sig0",  64'(sig0),  64'd0);
    check_val("rst_sig1",  64'(sig1),  64'd0);
    check_val("rst_sent",  64'(sent),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // seed=1, count=4, ready high: low bytes 01 03 02 01
    run(4, 32'h1, 100, 0);
    check_val("seq_len", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      check_val("seq0", 64'(got_q[0][7:0]), 64'h01);
      check_val("seq1", 64'(got_q[1][7:0]), 64'h03);
      check_val("seq2", 64'(got_q[2][7:0]), 64'h02);
      check_val("seq3", 64'(got_q[3][7:0]), 64'h01);
    end

    // same run with a 3-cycle stall after the first vector
    run(4, 32'h1, 100, 2);
    check_val("stall_len", 64'(got_q.size()), 64'd4);

    // zero-count run
    run(0, 32'h1234, 0, 0);

    // replication of the low LFSR byte onto bits 32..39
    run(3, 32'h8020_0003, 100, 0);
    if (got_q.size() != 0) check_val("wide_first", 64'(got_q[0]), 64'h03_8020_0003);
    else check_val("wide_first_len", 64'(got_q.size()), 64'd3);

    // reset during the second vector
    @(negedge clk);
    start = 1'b1;
    count = CNT_W'(4);
    seed  = 32'h1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("pre_rst_valid", 64'(valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(valid), 64'd0);
    check_val("mid_rst_busy",  64'(busy),  64'd0);
    check_val("mid_rst_done",  64'(done),  64'd0);
    check_val("mid_rst_sig0",  64'(sig0),  64'd0);
    check_val("mid_rst_sig1",  64'(sig1),  64'd0);
    check_val("mid_rst_sent",  64'(sent),  64'd0);
    ready = 1'b0;
    @(negedge clk);
    check_val("rst_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    // zero seed falls back to the default seed
    run(3, 32'h0, 100, 0);
    if (got_q.size() != 0) check_val("zero_seed", 64'(got_q[0]), 64'h01_0000_0001);
    else check_val("zero_seed_len", 64'(got_q.size()), 64'd3);

    // injection at index 2 (ignored when the feature is absent)
    run(4, 32'h1, 2, 0);

    // randomized runs with random ready and start noise during RUN
    for (int n = 0; n < 20; n++) begin
      c = int'($urandom_range(0, 12));
      run(c, $urandom, int'($urandom_range(0, 14)), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
